// File: rtl/lsu_word_mem_if.sv
// Load/store unit in front of a word-addressed RAM with combinational read and clocked write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of ignoring low bits.
module lsu_word_mem_if #(
  parameter int unsigned MEMSZ = 64,
  localparam int unsigned AW = $clog2(MEMSZ)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_fault,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [32:0] ByteLimit = 33'(MEMSZ) << 2;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        illegal;
  logic        out_of_range;
  logic        misalign;
  logic        access_fault;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] store_data;

  // Fault decode on the latched request
  always_comb begin
    illegal = 1'b0;
    if (we_q) begin
      illegal = !(funct3_q inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = funct3_q inside {3'b011, 3'b110, 3'b111};
    end
    out_of_range = {1'b0, addr_q} >= ByteLimit;
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (funct3_q[1:0])
      2'b01:   misalign = addr_q[0];
      2'b10:   misalign = (addr_q[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
`endif
    access_fault = illegal || out_of_range || misalign;
  end

  // Lane select and extension for loads
  always_comb begin
    byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {24'h0, byte_lane};
      3'b101:  load_data = {16'h0, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  // Read-merge-write: untouched lanes come from the same-cycle RAM read
  always_comb begin
    store_data = mem_rdata;
    case (funct3_q[1:0])
      2'b00: store_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) begin
          store_data[31:16] = wdata_q[15:0];
        end else begin
          store_data[15:0] = wdata_q[15:0];
        end
      end
      default: store_data = wdata_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req_valid) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = rdata_q;
    resp_fault = fault_q;
    mem_addr   = addr_q[AW+1:2];
    mem_we     = (state_q == StAccess) && we_q && !access_fault;
    mem_wdata  = mem_we ? store_data : 32'h0;
  end

  // Request latch and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
          end
        end
        StAccess: begin
          fault_q <= access_fault;
          rdata_q <= (!access_fault && !we_q) ? load_data : 32'h0;
        end
        StResp: begin
          if (resp_ready) begin
            fault_q <= 1'b0;
            rdata_q <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_word_mem_if.sv
// Randomized and directed bench for lsu_word_mem_if against a byte-array memory model.
// Honours LSU_MISALIGN_TRAP_EN when computing expected faults.
module tb_lsu_word_mem_if;

  localparam int unsigned MEMSZ = 64;
  localparam int unsigned AW = $clog2(MEMSZ);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  lsu_word_mem_if #(.MEMSZ(MEMSZ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached RAM
  logic [31:0] ram [MEMSZ];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  int we_count = 0;
  always @(posedge clk) if (mem_we) we_count <= we_count + 1;

  logic [7:0] ref_bytes [MEMSZ*4];
  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rd;
  logic        exp_f;
  logic        exp_write;
  logic [31:0] got_rd;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  int          wc0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v = v + (32'(ref_bytes[w*4+i]) << (8*i));
    return v;
  endfunction

  // Behavioural model: byte memory, little-endian, size-based lanes
  task automatic ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    int size;
    logic legal;
    logic [31:0] base, val;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    flt   = !legal || (a >= MEMSZ * 4);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % size) != 0) flt = 1'b1;
`endif
    base = a - (a % size);
    rd = 0;
    if (!flt) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_bytes[base+i] = wd[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < size; i++) val = val + (32'(ref_bytes[base+i]) << (8*i));
        if (!f3[2] && size < 4 && val >= (32'd1 << (8*size-1))) val = val - (32'd1 << (8*size));
        rd = val;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
    int n;
    ref_exec(we, f3, a, wd, exp_rd, exp_f);
    exp_write = we && !exp_f;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    wc0 = we_count;
    acc_we = mem_we; acc_addr = 32'(mem_addr); acc_wdata = mem_wdata;
    check({tag, " mem_we"}, 32'(acc_we), 32'(exp_write));
  endtask

  task automatic finish(input string tag);
    int n;
    n = 0;
    while (!resp_valid && n < 8) begin @(posedge clk); #1; n++; end
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " rdata"}, resp_rdata, exp_rd);
    check({tag, " fault"}, 32'(resp_fault), 32'(exp_f));
    check({tag, " writes"}, 32'(we_count - wc0), exp_write ? 32'd1 : 32'd0);
    got_rd = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " resp_done"}, {31'(resp_rdata), resp_valid}, 32'd0);
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    issue(we, f3, a, wd, tag);
    finish(tag);
  endtask

  initial begin
    logic [31:0] a, w, held;
    logic [2:0]  f;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 0; req_wdata = 0; resp_ready = 1'b0;
    for (int i = 0; i < int'(MEMSZ); i++) begin
      w = $urandom;
      ram[i] = w;
      for (int b = 0; b < 4; b++) ref_bytes[i*4+b] = w[8*b +: 8];
    end
    repeat (2) @(negedge clk);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_fault", 32'(resp_fault), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;

    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw");
    check("sw mem_addr", acc_addr, 32'd4);
    check("sw mem_wdata", acc_wdata, 32'hDEADBEEF);
    txn(1'b0, 3'b000, 32'h13, 0, "lb");
    check("lb value", got_rd, 32'hFFFFFFDE);
    txn(1'b0, 3'b100, 32'h13, 0, "lbu");
    check("lbu value", got_rd, 32'h000000DE);
    txn(1'b0, 3'b001, 32'h10, 0, "lh");
    check("lh value", got_rd, 32'hFFFFBEEF);
    txn(1'b0, 3'b101, 32'h12, 0, "lhu");
    check("lhu value", got_rd, 32'h0000DEAD);
    txn(1'b1, 3'b000, 32'h11, 32'hABCDEF55, "sb");
    check("sb merge", acc_wdata, 32'hDEAD55EF);
    txn(1'b0, 3'b010, 32'h10, 0, "lw");
    check("lw after sb", got_rd, 32'hDEAD55EF);
    txn(1'b0, 3'b010, MEMSZ * 4, 0, "lw oor");
    check("lw oor fault", 32'(exp_f), 32'd1);
    txn(1'b1, 3'b011, 32'h20, 32'h1234, "st f3=011");
    txn(1'b1, 3'b010, 32'hFFFFFFFC, 32'h1, "sw high");
    txn(1'b0, 3'b001, 32'h11, 0, "lh 0x11");
`ifndef LSU_MISALIGN_TRAP_EN
    check("lh 0x11 low half", got_rd, 32'h000055EF);
`endif

    // Response stall
    issue(1'b0, 3'b010, 32'h10, 0, "stall");
    @(posedge clk); #1;
    held = resp_rdata;
    for (int i = 0; i < 5; i++) begin
      check("stall valid", 32'(resp_valid), 32'd1);
      check("stall rdata", resp_rdata, held);
      check("stall req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    finish("stall");

    // Reset while a store is in ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20;
    req_wdata = ~ref_word(8);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst access mem_we before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst access mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst access ram", ram[8], ref_word(8));
    check("rst access resp_valid", 32'(resp_valid), 32'd0);

    // Reset while a response is pending
    issue(1'b0, 3'b010, 32'h20, 0, "rst resp");
    @(posedge clk); #1;
    check("rst resp pre valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst resp valid", 32'(resp_valid), 32'd0);
    check("rst resp rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(MEMSZ * 4, MEMSZ * 4 + 40));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, MEMSZ * 4 - 1));
      endcase
      txn(1'($urandom_range(0, 1)), f, a, $urandom, "rand");
    end

    for (int i = 0; i < int'(MEMSZ); i++) check("final ram", ram[i], ref_word(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
